module_status_counter: RTL and testbench
========================================

// Module: module_status_counter
// PURPOSE
//  Synthesizable, parametrised successor to the per-module ap_start/ap_ready/ap_done status
//  monitors. Tracks NUM_CH HLS block-level handshakes in hardware and keeps per-channel
//  statistics: transaction count, latency (last/min/max), busy cycles and done-stall cycles.
//  Sits beside the myproject top and its sub-instances (hept, pairwise_dist_sq_rbf,
//  mask_and_normalize, ...). Statistics are read through a registered select port.
// PARAMETERS
//  NUM_CH  6   number of monitored channels (1..16)
//  CNT_W   32  width of every counter/statistic (8..32); all counters saturate at 2^CNT_W-1
//  CH_W    4   width of rd_ch; must satisfy 2^CH_W >= NUM_CH
// PORTS
//  clock        in   1            single clock; all logic on posedge
//  reset        in   1            asynchronous, active-low reset (0 = in reset)
//  ap_start     in   NUM_CH       per-channel ap_start of the monitored block
//  ap_ready     in   NUM_CH       per-channel ap_ready (informational; drives no state)
//  ap_done      in   NUM_CH       per-channel ap_done
//  ap_continue  in   NUM_CH       per-channel ap_continue; tie to 1 for non-dataflow blocks
//  finish       in   1            end of run; sticky freeze of all counters
//  clear_stats  in   1            synchronous pulse; zeroes statistics
//  rd_en        in   1            read request
//  rd_ch        in   CH_W         channel to read
//  rd_sel       in   3            statistic select (see BEHAVIOUR)
//  rd_data      out  CNT_W        read result
//  rd_valid     out  1            rd_data valid
//  frozen       out  1            high once finish has been seen
// BEHAVIOUR
//  Reset (reset=0): FSMs to IDLE; counters to 0; min_lat to all-ones; rd_data=0; rd_valid=0;
//   frozen=0. Outputs change asynchronously on entry to reset.
//  Per-channel FSM:
//   IDLE: ap_start=1 begins a transaction and sets lat_cnt=1.
//     If ap_done=1 in the same cycle, the transaction also ends in that cycle:
//     ap_continue=1 gives latency=1 and stays in IDLE; ap_continue=0 gives latency=1 and goes to HOLD.
//     With ap_done=0 the FSM goes to BUSY.
//   BUSY: ap_done=0 increments lat_cnt. ap_done=1 ends the transaction:
//     latency=lat_cnt+1; ap_continue=1 goes to IDLE, ap_continue=0 goes to HOLD.
//   HOLD: stall_cnt increments every cycle ap_continue=0. ap_continue=1 goes to IDLE.
//     ap_done/ap_start are ignored in HOLD.
//   A new start is accepted no earlier than the cycle after returning to IDLE.
//   One transaction in flight per channel.
//  On transaction end (in the cycle ap_done is sampled):
//   txn_cnt++; last_lat=latency; min_lat=min(min_lat,latency); max_lat=max(max_lat,latency).
//  busy_cnt increments in every cycle the FSM is in BUSY or the start cycle.
//  glob_cnt increments every cycle after reset; it is shared by all channels.
//  Saturation: no counter wraps; each holds at 2^CNT_W-1. lat_cnt saturates too, so latency is
//   reported as max.
//  clear_stats=1: in the next state, txn/last/max/busy/stall/glob are 0 and min is all-ones.
//   FSM state and lat_cnt of in-flight transactions are preserved.
//   Clear wins over a same-cycle transaction end, which is dropped from the stats.
//  finish=1: frozen is set from the next cycle until reset. While frozen, statistics and glob_cnt
//   hold, FSMs keep tracking, and reads still work. clear_stats still clears while frozen.
//  Read port: rd_en is sampled at posedge; rd_data/rd_valid follow one cycle later; rd_valid is
//   a 1-cycle pulse. Back-to-back reads are allowed every cycle.
//   rd_sel: 0 txn_cnt, 1 last_lat, 2 min_lat, 3 max_lat, 4 busy_cnt, 5 stall_cnt,
//   6 {zero-pad, state[1:0]} (IDLE=0, BUSY=1, HOLD=2), 7 glob_cnt.
//   Read data is the pre-update value of the read cycle.
//   rd_ch>=NUM_CH gives rd_data=0 with rd_valid=1.
//   rd_data holds its last value when rd_valid=0.
// TESTING
//  T1 ch0: start at cycle 10, done+continue at cycle 14 -> txn=1, last=min=max=5, busy=5, stall=0.
//  T2 ch1: done=1 while ap_continue=0 for 3 cycles, then continue=1 -> stall=3, FSM back to IDLE;
//     rd_sel=6 during hold reads 2.
//  T3 ch2: start and done in the same cycle, continue=1, three times back-to-back
//     (start every 2nd cycle) -> txn=3, min=max=1.
//  T4 CNT_W=8, ch0 BUSY for 300 cycles -> last_lat=255, busy_cnt=255, no wrap.
//  T5 clear_stats in the same cycle as a ch0 done -> txn=0 and min=0xFF..;
//     a subsequent transaction is counted normally.
//  T6 reset=0 asserted mid-BUSY on ch3 -> rd_data/rd_valid=0 immediately; after release,
//     state reads 0 and txn reads 0. finish then freezes glob_cnt (two reads 5 cycles apart
//     are equal).

Source files
------------

// File: rtl/module_status_counter.sv
// Per-channel HLS block-level handshake monitor with saturating statistics
// (transactions, latency last/min/max, busy and done-stall cycles) and a registered read port.
module module_status_counter #(
  parameter int unsigned NUM_CH = 6,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned CH_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              finish,
  input  logic              clear_stats,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              frozen
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state_q [NUM_CH];
  logic [1:0]       state_d [NUM_CH];
  logic [CNT_W-1:0] lat_q   [NUM_CH];
  logic [CNT_W-1:0] lat_d   [NUM_CH];
  logic [CNT_W-1:0] txn_q   [NUM_CH];
  logic [CNT_W-1:0] txn_d   [NUM_CH];
  logic [CNT_W-1:0] last_q  [NUM_CH];
  logic [CNT_W-1:0] last_d  [NUM_CH];
  logic [CNT_W-1:0] min_q   [NUM_CH];
  logic [CNT_W-1:0] min_d   [NUM_CH];
  logic [CNT_W-1:0] max_q   [NUM_CH];
  logic [CNT_W-1:0] max_d   [NUM_CH];
  logic [CNT_W-1:0] busy_q  [NUM_CH];
  logic [CNT_W-1:0] busy_d  [NUM_CH];
  logic [CNT_W-1:0] stall_q [NUM_CH];
  logic [CNT_W-1:0] stall_d [NUM_CH];

  logic             end_txn [NUM_CH];
  logic [CNT_W-1:0] end_lat [NUM_CH];
  logic             busy_inc[NUM_CH];
  logic             stall_inc[NUM_CH];

  logic [CNT_W-1:0] glob_q, glob_d;
  logic             frozen_q, frozen_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_word;

  // ap_ready is informational only; reduced here so it is consumed.
  logic ready_unused;
  assign ready_unused = ^ap_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i]   = state_q[i];
      lat_d[i]     = lat_q[i];
      end_txn[i]   = 1'b0;
      end_lat[i]   = '0;
      busy_inc[i]  = 1'b0;
      stall_inc[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (ap_start[i]) begin
            lat_d[i]    = CNT_W'(1);
            busy_inc[i] = 1'b1;
            if (ap_done[i]) begin
              end_txn[i] = 1'b1;
              end_lat[i] = CNT_W'(1);
              state_d[i] = ap_continue[i] ? IDLE : HOLD;
            end else begin
              state_d[i] = BUSY;
            end
          end
        end
        BUSY: begin
          busy_inc[i] = 1'b1;
          if (ap_done[i]) begin
            end_txn[i] = 1'b1;
            end_lat[i] = sat_inc(lat_q[i]);
            state_d[i] = ap_continue[i] ? IDLE : HOLD;
          end else begin
            lat_d[i] = sat_inc(lat_q[i]);
          end
        end
        HOLD: begin
          if (ap_continue[i]) state_d[i] = IDLE;
          else                stall_inc[i] = 1'b1;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Clear overrides freeze and drops any transaction ending in the same cycle;
  // FSM state and in-flight lat_cnt are left untouched by both.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      txn_d[i]   = txn_q[i];
      last_d[i]  = last_q[i];
      min_d[i]   = min_q[i];
      max_d[i]   = max_q[i];
      busy_d[i]  = busy_q[i];
      stall_d[i] = stall_q[i];
      if (clear_stats) begin
        txn_d[i]   = '0;
        last_d[i]  = '0;
        min_d[i]   = '1;
        max_d[i]   = '0;
        busy_d[i]  = '0;
        stall_d[i] = '0;
      end else if (!frozen_q) begin
        if (end_txn[i]) begin
          txn_d[i]  = sat_inc(txn_q[i]);
          last_d[i] = end_lat[i];
          if (end_lat[i] < min_q[i]) min_d[i] = end_lat[i];
          if (end_lat[i] > max_q[i]) max_d[i] = end_lat[i];
        end
        if (busy_inc[i])  busy_d[i]  = sat_inc(busy_q[i]);
        if (stall_inc[i]) stall_d[i] = sat_inc(stall_q[i]);
      end
    end
  end

  always_comb begin
    glob_d   = glob_q;
    frozen_d = frozen_q | finish;
    if (clear_stats)    glob_d = '0;
    else if (!frozen_q) glob_d = sat_inc(glob_q);
  end

  // Out-of-range channels match no entry and read back as zero.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        case (rd_sel)
          3'd0:    rd_word = txn_q[i];
          3'd1:    rd_word = last_q[i];
          3'd2:    rd_word = min_q[i];
          3'd3:    rd_word = max_q[i];
          3'd4:    rd_word = busy_q[i];
          3'd5:    rd_word = stall_q[i];
          3'd6:    rd_word = CNT_W'(state_q[i]);
          default: rd_word = glob_q;
        endcase
      end
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_en) begin
      rd_data_d  = rd_word;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        lat_q[i]   <= '0;
        txn_q[i]   <= '0;
        last_q[i]  <= '0;
        min_q[i]   <= '1;
        max_q[i]   <= '0;
        busy_q[i]  <= '0;
        stall_q[i] <= '0;
      end
      glob_q     <= '0;
      frozen_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        lat_q[i]   <= lat_d[i];
        txn_q[i]   <= txn_d[i];
        last_q[i]  <= last_d[i];
        min_q[i]   <= min_d[i];
        max_q[i]   <= max_d[i];
        busy_q[i]  <= busy_d[i];
        stall_q[i] <= stall_d[i];
      end
      glob_q     <= glob_d;
      frozen_q   <= frozen_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign frozen   = frozen_q;

endmodule

// File: tb/tb_module_status_counter.sv
// Bench for module_status_counter: cycle-timestamp transaction model checked every cycle,
// plus directed scenarios with literal expected statistics.
module tb_module_status_counter;
  localparam int NC   = 6;
  localparam int CW   = 8;
  localparam int MAXV = 255;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NC-1:0] ap_start = '0, ap_ready = '0, ap_done = '0, ap_continue = '1;
  logic          finish = 1'b0, clear_stats = 1'b0, rd_en = 1'b0;
  logic [3:0]    rd_ch = '0;
  logic [2:0]    rd_sel = '0;
  logic [CW-1:0] rd_data;
  logic          rd_valid, frozen;

  int checks = 0;
  int errors = 0;

  module_status_counter #(.NUM_CH(NC), .CNT_W(CW), .CH_W(4)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .clear_stats(clear_stats), .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_valid(rd_valid), .frozen(frozen)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Model: phase 0 idle, 1 in flight, 2 waiting for continue; latency from start timestamp.
  int  ph[NC], t0[NC], txn[NC], lastl[NC], mn[NC], mx[NC], bsy[NC], stl[NC];
  int  glob = 0, cyc = 0, exp_data = 0;
  bit  frz = 0, exp_valid = 0;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NC; c++) begin
        ph[c] = 0; t0[c] = 0; txn[c] = 0; lastl[c] = 0; mn[c] = MAXV;
        mx[c] = 0; bsy[c] = 0; stl[c] = 0;
      end
      glob = 0; cyc = 0; frz = 0; exp_data = 0; exp_valid = 0;
    end else begin
      exp_valid = rd_en;
      if (rd_en) begin
        if (int'(rd_ch) >= NC) exp_data = 0;
        else begin
          case (rd_sel)
            3'd0: exp_data = txn[rd_ch];
            3'd1: exp_data = lastl[rd_ch];
            3'd2: exp_data = mn[rd_ch];
            3'd3: exp_data = mx[rd_ch];
            3'd4: exp_data = bsy[rd_ch];
            3'd5: exp_data = stl[rd_ch];
            3'd6: exp_data = ph[rd_ch];
            default: exp_data = glob;
          endcase
        end
      end
      for (int c = 0; c < NC; c++) begin
        bit ended, inbusy, install;
        int lat;
        ended = 0; inbusy = 0; install = 0; lat = 0;
        if (ph[c] == 0 && ap_start[c]) begin
          t0[c] = cyc; inbusy = 1;
          if (ap_done[c]) begin ended = 1; ph[c] = ap_continue[c] ? 0 : 2; end
          else ph[c] = 1;
        end else if (ph[c] == 1) begin
          inbusy = 1;
          if (ap_done[c]) begin ended = 1; ph[c] = ap_continue[c] ? 0 : 2; end
        end else if (ph[c] == 2) begin
          if (ap_continue[c]) ph[c] = 0; else install = 1;
        end
        if (ended) lat = sat(cyc - t0[c] + 1);
        if (clear_stats) begin
          txn[c] = 0; lastl[c] = 0; mn[c] = MAXV; mx[c] = 0; bsy[c] = 0; stl[c] = 0;
        end else if (!frz) begin
          if (ended) begin
            txn[c] = sat(txn[c] + 1); lastl[c] = lat;
            if (lat < mn[c]) mn[c] = lat;
            if (lat > mx[c]) mx[c] = lat;
          end
          if (inbusy)  bsy[c] = sat(bsy[c] + 1);
          if (install) stl[c] = sat(stl[c] + 1);
        end
      end
      if (clear_stats) glob = 0;
      else if (!frz)   glob = sat(glob + 1);
      if (finish) frz = 1;
      cyc++;
    end
  end

  always @(negedge clock) begin
    chk("rd_valid", int'(rd_valid), int'(exp_valid));
    chk("rd_data", int'(rd_data), exp_data);
    chk("frozen", int'(frozen), int'(frz));
  end

  task automatic cyc1();
    @(negedge clock);
  endtask

  task automatic rd(input int ch, input int sel, output int val);
    rd_en = 1'b1; rd_ch = 4'(ch); rd_sel = 3'(sel);
    @(negedge clock);
    val = int'(rd_data);
    rd_en = 1'b0;
  endtask

  int v, g;

  initial begin
    cyc1();
    chk("reset_rd_valid", int'(rd_valid), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_frozen", int'(frozen), 0);
    cyc1();
    reset = 1'b1;
    repeat (3) cyc1();

    // T1: start, 3 busy cycles, done+continue -> latency 5
    ap_start[0] = 1; cyc1(); ap_start[0] = 0;
    repeat (3) cyc1();
    ap_done[0] = 1; cyc1(); ap_done[0] = 0;
    rd(0, 0, v); chk("t1_txn", v, 1);
    rd(0, 1, v); chk("t1_last", v, 5);
    rd(0, 2, v); chk("t1_min", v, 5);
    rd(0, 3, v); chk("t1_max", v, 5);
    rd(0, 4, v); chk("t1_busy", v, 5);
    rd(0, 5, v); chk("t1_stall", v, 0);

    // T2: done without continue, three stalled HOLD cycles
    ap_start[1] = 1; cyc1(); ap_start[1] = 0;
    ap_continue[1] = 0; ap_done[1] = 1; cyc1(); ap_done[1] = 0;
    rd(1, 6, v); chk("t2_state_hold", v, 2);
    repeat (2) cyc1();
    ap_continue[1] = 1; cyc1();
    rd(1, 6, v); chk("t2_state_idle", v, 0);
    rd(1, 5, v); chk("t2_stall", v, 3);
    rd(1, 1, v); chk("t2_last", v, 2);

    // T3: single-cycle transactions, start every 2nd cycle
    for (int k = 0; k < 3; k++) begin
      ap_start[2] = 1; ap_done[2] = 1; cyc1();
      ap_start[2] = 0; ap_done[2] = 0; cyc1();
    end
    rd(2, 0, v); chk("t3_txn", v, 3);
    rd(2, 2, v); chk("t3_min", v, 1);
    rd(2, 3, v); chk("t3_max", v, 1);
    rd(2, 4, v); chk("t3_busy", v, 3);

    // T5: clear coincident with a done drops that transaction
    ap_start[0] = 1; cyc1(); ap_start[0] = 0; cyc1();
    ap_done[0] = 1; clear_stats = 1; cyc1(); ap_done[0] = 0; clear_stats = 0;
    rd(0, 0, v); chk("t5_txn_cleared", v, 0);
    rd(0, 2, v); chk("t5_min_cleared", v, MAXV);
    rd(1, 5, v); chk("t5_stall_cleared", v, 0);
    ap_start[0] = 1; cyc1(); ap_start[0] = 0; ap_done[0] = 1; cyc1(); ap_done[0] = 0;
    rd(0, 0, v); chk("t5_txn_after", v, 1);
    rd(0, 1, v); chk("t5_last_after", v, 2);
    rd(0, 2, v); chk("t5_min_after", v, 2);

    // T4: 302-cycle transaction saturates the 8-bit counters
    ap_start[0] = 1; cyc1(); ap_start[0] = 0;
    repeat (300) cyc1();
    ap_done[0] = 1; cyc1(); ap_done[0] = 0;
    rd(0, 1, v); chk("t4_last_sat", v, MAXV);
    rd(0, 4, v); chk("t4_busy_sat", v, MAXV);
    rd(0, 0, v); chk("t4_txn", v, 2);
    rd(0, 2, v); chk("t4_min", v, 2);
    rd(0, 7, v); chk("t4_glob_sat", v, MAXV);

    rd(6, 0, v);  chk("oor_ch6", v, 0);
    rd(15, 7, v); chk("oor_ch15", v, 0);

    // T6: asynchronous reset while ch3 is busy
    ap_start[3] = 1; cyc1(); ap_start[3] = 0;
    repeat (3) cyc1();
    rd(3, 4, v); chk("t6_busy_pre", v, 4);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_rd_data", int'(rd_data), 0);
    chk("t6_rst_rd_valid", int'(rd_valid), 0);
    cyc1(); cyc1();
    reset = 1'b1;
    repeat (2) cyc1();
    rd(3, 6, v); chk("t6_state", v, 0);
    rd(3, 0, v); chk("t6_txn", v, 0);
    finish = 1; cyc1(); finish = 0;
    chk("t6_frozen", int'(frozen), 1);
    rd(0, 7, g); chk("t6_glob_a", g, 5);
    repeat (5) cyc1();
    rd(0, 7, g); chk("t6_glob_b", g, 5);

    clear_stats = 1; cyc1(); clear_stats = 0;
    rd(0, 7, v); chk("frozen_clear_glob", v, 0);
    repeat (3) cyc1();
    rd(0, 7, v); chk("frozen_glob_hold", v, 0);
    chk("still_frozen", int'(frozen), 1);
    cyc1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
